// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   UART transmit stage. Accepts a write strobe plus a data byte while idle and
//   sends it as an 8N1 frame: one low start bit, eight data bits LSB first,
//   one high stop bit. Each bit lasts CLKS_PER_BIT clock cycles.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per bit period (2..65535)
//   CNT_W        : bit-period counter width, 2**CNT_W > CLKS_PER_BIT
//
// Ports
//   clk_i   : system clock, rising-edge active
//   rst_i   : asynchronous active-high reset; aborts any frame in progress
//   start_i : transmit request, honoured only while idle
//   data_i  : byte to send, sampled on the accepting edge only
//   tx_o    : serial line, idles high (registered)
//   busy_o  : high while a frame is on the line (registered)
//   done_o  : one-cycle pulse in the first idle cycle after a frame (registered)
module uart_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_d, busy_d, done_d;
  logic             bit_end;

  assign bit_end = (cnt_q == LAST_CNT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_o    <= 1'b1;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_o    <= tx_d;
      busy_o  <= busy_d;
      done_o  <= done_d;
    end
  end

  // Outputs are registered, so tx_d/busy_d/done_d describe the line level of
  // the state being entered rather than the current one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    busy_d  = 1'b1;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start_i) begin
          shift_d = data_i;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
          tx_d  = 1'b0;
        end
      end

      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
            // Next data bit is the one about to shift into position 0.
            tx_d  = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          tx_d  = shift_q[0];
        end
      end

      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

  localparam int C  = 4;
  localparam int C2 = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data = '0;
  logic       tx, busy, done;

  logic       start2 = 1'b0;
  logic [7:0] data2 = '0;
  logic       tx2, busy2, done2;

  int total = 0;
  int bad = 0;

  logic [7:0] exp_q[$];
  int         n_accept = 0;
  int         left = 0;
  int         frames_done = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(C), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .data_i(data),
    .tx_o(tx), .busy_o(busy), .done_o(done)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(C2), .CNT_W(8)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .data_i(data2),
    .tx_o(tx2), .busy_o(busy2), .done_o(done2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: a request is taken when the line has been free long
  // enough; a taken frame keeps the transmitter unavailable for 10 bit times.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      left = 0;
    end else if (left > 0) begin
      left--;
    end else if (start) begin
      exp_q.push_back(data);
      left = 10 * C;
      n_accept++;
    end
  end

  function automatic logic wave_bit(input logic [7:0] b, input int c);
    int k;
    k = c / C;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  // Monitor: compares every cycle of the line against the expected frame.
  initial begin
    logic [7:0] b;
    bit aborted;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'd1, 32'd0);
          b = '0;
        end else begin
          b = exp_q.pop_front();
        end
        aborted = 1'b0;
        for (int c = 0; c < 10 * C; c++) begin
          if (c > 0) @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          chk("frame_tx", {31'd0, tx}, {31'd0, wave_bit(b, c)});
          chk("frame_busy", {31'd0, busy}, 32'd1);
          chk("frame_done", {31'd0, done}, 32'd0);
        end
        if (!aborted) begin
          @(negedge clk);
          if (!rst) begin
            chk("done_pulse", {31'd0, done}, 32'd1);
            chk("done_busy", {31'd0, busy}, 32'd0);
            chk("done_tx", {31'd0, tx}, 32'd1);
            frames_done++;
          end
        end
      end else begin
        chk("idle_tx", {31'd0, tx}, 32'd1);
        chk("idle_done", {31'd0, done}, 32'd0);
      end
    end
  end

  task automatic pulse(input logic [7:0] d);
    @(negedge clk);
    start = 1'b1;
    data  = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_free();
    int n = 0;
    while ((left != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_free_timeout", {31'd0, (n >= 200)}, 32'd0);
  endtask

  initial begin
    logic [19:0] e2;
    int base;
    int n;

    // Reset asserted mid-cycle, held three cycles.
    #2 rst = 1'b1;
    #1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_tx", {31'd0, tx}, 32'd1);
    chk("rel_busy", {31'd0, busy}, 32'd0);
    repeat (100) @(negedge clk);
    chk("idle_no_frames", frames_done, 0);

    // Single frame.
    pulse(8'hA5);
    repeat (45) @(negedge clk);
    chk("single_count", frames_done, 1);

    // Second request mid-frame is ignored.
    pulse(8'h00);
    repeat (14) @(negedge clk);
    start = 1'b1;
    data  = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    data  = 8'h5A;
    repeat (60) @(negedge clk);
    chk("ignore_count", frames_done, 2);

    // Back-to-back with start held high.
    base = n_accept;
    @(negedge clk);
    start = 1'b1;
    data  = 8'h3C;
    n = 0;
    while (n_accept < base + 2 && n < 200) begin
      @(negedge clk);
      if (n_accept == base + 1) data = 8'hC3;
      n++;
    end
    start = 1'b0;
    chk("b2b_timeout", {31'd0, (n >= 200)}, 32'd0);
    repeat (50) @(negedge clk);
    chk("b2b_count", frames_done, 4);

    // Reset during data bit 3.
    pulse(8'h96);
    repeat (17) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tx", {31'd0, tx}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_no_done", frames_done, 4);
    pulse(8'h69);
    repeat (45) @(negedge clk);
    chk("after_rst_count", frames_done, 5);

    // Random frames with data_i wandering during the frame.
    for (int f = 0; f < 4; f++) begin
      wait_free();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pulse(8'($urandom));
      for (int k = 0; k < 10 * C; k++) begin
        @(negedge clk);
        data = 8'($urandom);
      end
    end
    wait_free();
    repeat (5) @(negedge clk);
    chk("random_count", frames_done, 9);

    // Minimum bit period on the second instance.
    e2 = 20'hC000C;
    @(negedge clk);
    start2 = 1'b1;
    data2  = 8'h01;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      chk("c2_tx", {31'd0, tx2}, {31'd0, e2[i]});
      chk("c2_busy", {31'd0, busy2}, 32'd1);
    end
    @(negedge clk);
    chk("c2_done", {31'd0, done2}, 32'd1);
    chk("c2_end_busy", {31'd0, busy2}, 32'd0);
    chk("c2_end_tx", {31'd0, tx2}, 32'd1);

    repeat (20) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    chk("final_count", frames_done, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
